// File: rtl/divider_pkg.sv
// Shared types for the restoring-division control slice.
// SCAN_TEST_EN adds the SCAN state used by the scan-chain sequencer.
package divider_pkg;

    localparam int DIV_WIDTH = 8;
    localparam int STATE_W   = 3;

    typedef enum logic [STATE_W-1:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_CHECK = 3'd2,
        S_SHIFT = 3'd3,
        S_TRIAL = 3'd4,
        S_DONE  = 3'd5
`ifdef SCAN_TEST_EN
        ,
        S_SCAN  = 3'd6
`endif
    } state_t;

    typedef struct packed {
        logic load_a;
        logic load_b;
        logic load_m;
        logic load_result;
        logic enable_op1;
        logic enable_op2;
        logic enable_sub;
        logic enable_zero;
        logic increment;
        logic test;
    } ctrl_t;

    localparam int CTRL_W = $bits(ctrl_t);

endpackage

// File: rtl/divider_ctrl_decode.sv
// State-to-control-word decode for the bitslice array.
// SCAN_TEST_EN enables the Test strobe decode for the SCAN state.
module divider_ctrl_decode
    import divider_pkg::*;
(
    input  logic [STATE_W-1:0] state_i,
    output logic [CTRL_W-1:0]  ctrl_o
);

    ctrl_t ctrl;

    always_comb begin
        ctrl = '0;
        case (state_t'(state_i))
            S_LOAD: begin
                ctrl.load_m      = 1'b1;
                ctrl.enable_op2  = 1'b1;
                ctrl.load_b      = 1'b1;
                ctrl.enable_op1  = 1'b1;
                ctrl.load_a      = 1'b1;
                ctrl.enable_zero = 1'b1;
            end
            S_SHIFT: begin
                ctrl.load_a = 1'b1;
                ctrl.load_b = 1'b1;
            end
            // load_result/increment mark eligibility; the top qualifies them with the MSB borrow
            S_TRIAL: begin
                ctrl.enable_sub  = 1'b1;
                ctrl.load_result = 1'b1;
                ctrl.increment   = 1'b1;
            end
`ifdef SCAN_TEST_EN
            S_SCAN: ctrl.test = 1'b1;
`endif
            default: ;
        endcase
    end

    assign ctrl_o = ctrl;

endmodule

// File: rtl/divider_control.sv
// Control sequencer for the 8-slice restoring-division datapath.
// Define SCAN_TEST_EN to add the ScanReq port and the SCAN sequence.
module divider_control
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH,
    parameter int CNT_W = $clog2(WIDTH + 1)
`ifdef SCAN_TEST_EN
    ,
    parameter int SCAN_LEN = 3 * WIDTH
`endif
) (
    input  logic clk_i,
    input  logic rst_i,
    input  logic start_i,
    output logic busy_o,
    output logic done_o,
    output logic div_by_zero_o,
    input  logic divisor_zero_i,
    input  logic nborrow_msb_i,
    output logic load_a_o,
    output logic load_b_o,
    output logic load_m_o,
    output logic load_result_o,
    output logic enable_op1_o,
    output logic enable_op2_o,
    output logic enable_sub_o,
    output logic enable_zero_o,
    output logic increment_o,
    output logic nborrow_lsb_o,
    output logic test_o
`ifdef SCAN_TEST_EN
    ,
    input  logic scan_req_i
`endif
);

`ifdef SCAN_TEST_EN
    localparam int SCAN_W = $clog2(SCAN_LEN + 1);
    localparam int CW     = (SCAN_W > CNT_W) ? SCAN_W : CNT_W;
    localparam logic [CW-1:0] SCAN_LAST = CW'(SCAN_LEN - 1);
`else
    localparam int CW = CNT_W;
`endif
    localparam logic [CW-1:0] ITER_LAST = CW'(WIDTH - 1);

    state_t          state_q;
    logic [CW-1:0]   count_q;
    logic            dbz_q;
    logic [CTRL_W-1:0] ctrl_bits;
    ctrl_t           ctrl;
    logic [STATE_W-1:0] state_bits;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= S_IDLE;
            count_q <= '0;
            dbz_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
`ifdef SCAN_TEST_EN
                    if (scan_req_i) begin
                        state_q <= S_SCAN;
                        count_q <= '0;
                    end else
`endif
                    if (start_i) begin
                        state_q <= S_LOAD;
                        dbz_q   <= 1'b0;
                    end
                end
                S_LOAD: begin
                    count_q <= '0;
                    state_q <= S_CHECK;
                end
                S_CHECK: begin
                    if (divisor_zero_i) begin
                        dbz_q   <= 1'b1;
                        state_q <= S_DONE;
                    end else begin
                        state_q <= S_SHIFT;
                    end
                end
                S_SHIFT: state_q <= S_TRIAL;
                S_TRIAL: begin
                    count_q <= count_q + 1'b1;
                    state_q <= (count_q == ITER_LAST) ? S_DONE : S_SHIFT;
                end
`ifdef SCAN_TEST_EN
                S_SCAN: begin
                    count_q <= count_q + 1'b1;
                    if (count_q == SCAN_LAST) state_q <= S_DONE;
                end
`endif
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign state_bits = state_q;

    divider_ctrl_decode u_decode (
        .state_i (state_bits),
        .ctrl_o  (ctrl_bits)
    );

    assign ctrl = ctrl_t'(ctrl_bits);

    assign busy_o        = (state_q != S_IDLE);
    assign done_o        = (state_q == S_DONE);
    assign div_by_zero_o = dbz_q;
    assign load_a_o      = ctrl.load_a;
    assign load_b_o      = ctrl.load_b;
    assign load_m_o      = ctrl.load_m;
    assign load_result_o = ctrl.load_result & nborrow_msb_i;
    assign enable_op1_o  = ctrl.enable_op1;
    assign enable_op2_o  = ctrl.enable_op2;
    assign enable_sub_o  = ctrl.enable_sub;
    assign enable_zero_o = ctrl.enable_zero;
    assign increment_o   = ctrl.increment & nborrow_msb_i;
    assign nborrow_lsb_o = 1'b1;
    assign test_o        = ctrl.test;

endmodule

// File: tb/tb_divider_control.sv
// Directed self-checking bench for divider_control (SCAN_TEST_EN adds the scan sequence check).
module tb_divider_control;

    logic clk = 1'b0;
    logic rst, start, dz, nbm;
    logic busy, done, dbz, la, lb, lm, lr, e1, e2, es, ez, inc, nbl, test;
`ifdef SCAN_TEST_EN
    logic scan_req;
`endif

    int n_assert = 0;
    int n_fail   = 0;

    // {busy,done,la,lb,lm,lr,e1,e2,es,ez,inc,test}
    localparam logic [11:0] V_IDLE    = 12'b0000_0000_0000;
    localparam logic [11:0] V_LOAD    = 12'b1011_1011_0100;
    localparam logic [11:0] V_CHECK   = 12'b1000_0000_0000;
    localparam logic [11:0] V_SHIFT   = 12'b1011_0000_0000;
    localparam logic [11:0] V_TRIAL_Q = 12'b1000_0100_1010;
    localparam logic [11:0] V_DONE    = 12'b1100_0000_0000;
    localparam logic [11:0] V_SCAN    = 12'b1000_0000_0001;

    divider_control dut (
        .clk_i          (clk),
        .rst_i          (rst),
        .start_i        (start),
        .busy_o         (busy),
        .done_o         (done),
        .div_by_zero_o  (dbz),
        .divisor_zero_i (dz),
        .nborrow_msb_i  (nbm),
        .load_a_o       (la),
        .load_b_o       (lb),
        .load_m_o       (lm),
        .load_result_o  (lr),
        .enable_op1_o   (e1),
        .enable_op2_o   (e2),
        .enable_sub_o   (es),
        .enable_zero_o  (ez),
        .increment_o    (inc),
        .nborrow_lsb_o  (nbl),
        .test_o         (test)
`ifdef SCAN_TEST_EN
        ,
        .scan_req_i     (scan_req)
`endif
    );

    always #5 clk = ~clk;

    function automatic logic [11:0] outs();
        return {busy, done, la, lb, lm, lr, e1, e2, es, ez, inc, test};
    endfunction

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        tick();
    endtask

    initial begin
        logic [7:0]  ma, mb, mm, qseen;
        logic [15:0] ab;
        logic        c_la, c_lb, c_lm, c_lr, c_e1, c_e2, c_ez, c_inc, c_es;
        int          done_cyc;

        rst = 1'b1; start = 1'b0; dz = 1'b0; nbm = 1'b0;
`ifdef SCAN_TEST_EN
        scan_req = 1'b0;
`endif
        #2;
        check("reset_outs", 32'(outs()), 32'(V_IDLE));
        check("reset_nbl", 32'(nbl), 32'd1);
        check("reset_dbz", 32'(dbz), 32'd0);
        rst = 1'b0;
        tick();

        // Full run with no borrow: every trial subtracts and sets a quotient bit.
        nbm = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("run_load", 32'(outs()), 32'(V_LOAD));
        tick();
        check("run_check", 32'(outs()), 32'(V_CHECK));
        for (int i = 0; i < 8; i++) begin
            tick();
            check($sformatf("run_shift%0d", i), 32'(outs()), 32'(V_SHIFT));
            tick();
            check($sformatf("run_trial%0d", i), 32'(outs()), 32'(V_TRIAL_Q));
        end
        tick();
        check("run_done19", 32'(outs()), 32'(V_DONE));
        check("run_dbz", 32'(dbz), 32'd0);
        tick();
        check("run_idle", 32'(outs()), 32'(V_IDLE));

        // Divide by zero: DONE in cycle 3, sticky flag until next start.
        dz = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        check("dbz_load", 32'(outs()), 32'(V_LOAD));
        tick();
        check("dbz_check", 32'(outs()), 32'(V_CHECK));
        tick();
        check("dbz_done3", 32'(outs()), 32'(V_DONE));
        check("dbz_flag", 32'(dbz), 32'd1);
        tick();
        check("dbz_idle", 32'(outs()), 32'(V_IDLE));
        tick();
        check("dbz_sticky", 32'(dbz), 32'd1);
        dz = 1'b0;
        start = 1'b1; tick(); start = 1'b0;
        check("dbz_cleared", 32'(dbz), 32'd0);
        check("dbz_restart_load", 32'(outs()), 32'(V_LOAD));
        do_reset();

        // Behavioural slice model: 200 / 7.
        ma = '0; mb = '0; mm = '0; qseen = '0; done_cyc = 0;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c <= 40 && done_cyc == 0; c++) begin
            nbm = (ma >= mm);
            #1;
            if (done) done_cyc = c;
            c_la = la; c_lb = lb; c_lm = lm; c_lr = lr; c_e1 = e1;
            c_e2 = e2; c_ez = ez; c_inc = inc; c_es = es;
            if (c_es) qseen = {qseen[6:0], c_inc};
            @(posedge clk);
            if (c_lm && c_e2) mm = 8'd7;
            if (c_lb && c_e1) mb = 8'd200;
            if (c_la && c_ez) ma = 8'd0;
            if (c_la && c_lb && !c_e1 && !c_e2 && !c_ez) begin
                ab = {ma, mb} << 1;
                ma = ab[15:8];
                mb = ab[7:0];
            end
            if (c_lr) ma = ma - mm;
            if (c_inc) mb[0] = 1'b1;
            #1;
        end
        check("div_done_cycle", 32'(done_cyc), 32'd19);
        check("div_quotient", 32'(mb), 32'd28);
        check("div_remainder", 32'(ma), 32'd4);
        check("div_borrow_pattern", 32'(qseen), 32'd28);
        check("div_dbz", 32'(dbz), 32'd0);
        tick();

        // Asynchronous reset in TRIAL with count=4 (cycle 12).
        nbm = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        for (int c = 1; c < 12; c++) tick();
        check("rst_pre_trial", 32'(outs()), 32'(V_TRIAL_Q));
        rst = 1'b1;
        #1;
        check("rst_async_outs", 32'(outs()), 32'(V_IDLE));
        check("rst_async_nbl", 32'(nbl), 32'd1);
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            tick();
            if (done || busy) check("rst_no_done", 32'(outs()), 32'(V_IDLE));
        end
        check("rst_idle_after", 32'(outs()), 32'(V_IDLE));

        // Start re-pulsed in SHIFT is ignored; start held across DONE relaunches after one IDLE cycle.
        start = 1'b1; tick(); start = 1'b0;
        tick(); tick();
        check("rp_shift", 32'(outs()), 32'(V_SHIFT));
        start = 1'b1; tick(); start = 1'b0;
        check("rp_trial_ignored", 32'(outs()), 32'(V_TRIAL_Q));
        for (int c = 4; c < 17; c++) tick();
        start = 1'b1;
        tick(); tick();
        check("rp_done19", 32'(outs()), 32'(V_DONE));
        tick();
        check("rp_idle20", 32'(outs()), 32'(V_IDLE));
        tick();
        check("rp_load21", 32'(outs()), 32'(V_LOAD));
        start = 1'b0;
        do_reset();

`ifdef SCAN_TEST_EN
        scan_req = 1'b1; start = 1'b1; tick(); scan_req = 1'b0; start = 1'b0;
        for (int i = 0; i < 24; i++) begin
            check($sformatf("scan_cyc%0d", i), 32'(outs()), 32'(V_SCAN));
            tick();
        end
        check("scan_done", 32'(outs()), 32'(V_DONE));
        tick();
        check("scan_idle", 32'(outs()), 32'(V_IDLE));
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
